// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pkg
// Brief    : Shared types, default parameters and width helper for the
//            push-button debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

  // Per-channel debounce state; the encoding is fixed at two bits.
  typedef enum logic [1:0] {
    REL   = 2'b00,
    PWAIT = 2'b01,
    PRS   = 2'b10,
    RWAIT = 2'b11
  } ch_state_t;

  localparam int unsigned DEF_KEY_W          = 8;
  localparam int unsigned DEF_TICK_CYCLES    = 100000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 20;

  // Ceiling log2, clamped to at least one bit so counters never collapse.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One key channel: 2-FF synchroniser, tick-counting debounce FSM,
//            registered stable level with press/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic tick,
  output logic key_db,
  output logic key_press,
  output logic key_release,
  output logic press_next
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_q;
  logic          key_sync;
  ch_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_d;
  logic          release_d;

  assign key_sync = sync_q[1];

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_raw};
  end

  // State, tick counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REL;
      cnt_q       <= '0;
      key_db      <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_db      <= db_d;
      key_press   <= press_next;
      key_release <= release_d;
    end
  end

  // Next-state logic: an opposite sample in a wait state aborts immediately;
  // the level is accepted on the tick that completes the required count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    db_d       = key_db;
    press_next = 1'b0;
    release_d  = 1'b0;
    case (state_q)
      REL: begin
        if (!key_sync) begin
          state_d = PWAIT;
          cnt_d   = '0;
        end
      end
      PWAIT: begin
        if (key_sync) begin
          state_d = REL;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d    = PRS;
            db_d       = 1'b0;
            press_next = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PRS: begin
        if (key_sync) begin
          state_d = RWAIT;
          cnt_d   = '0;
        end
      end
      RWAIT: begin
        if (!key_sync) begin
          state_d = PRS;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = REL;
            db_d      = 1'b1;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = REL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Debounces KEY_W active-low push buttons for the key PIO. Holds
//            the shared tick generator, the per-key channels and key_any.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned KEY_W          = DEF_KEY_W,
  parameter int unsigned TICK_CYCLES    = DEF_TICK_CYCLES,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_db,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic             key_any
);

  localparam int unsigned   TW        = cnt_width(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [KEY_W-1:0] press_next;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running tick counter shared by all channels; never restarted by keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  generate
    for (genvar k = 0; k < KEY_W; k++) begin : g_ch
      key_debounce_ch #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_in[k]),
        .tick       (tick),
        .key_db     (key_db[k]),
        .key_press  (key_press[k]),
        .key_release(key_release[k]),
        .press_next (press_next[k])
      );
    end
  endgenerate

  // key_any registered from the same next-values as key_press so they align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_any <= 1'b0;
    else        key_any <= |press_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce
// Brief    : Self-checking bench for key_debounce with short tick settings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

  localparam int TC = 10;
  localparam int DT = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_in;
  logic [7:0] key_db, key_press, key_release;
  logic       key_any;

  key_debounce #(
    .KEY_W(8), .TICK_CYCLES(TC), .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_db(key_db),
    .key_press(key_press), .key_release(key_release), .key_any(key_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: level is accepted when the synchronised input has
  // differed from the accepted level for DT whole tick boundaries.
  logic [7:0] m_db, m_press, m_rel, p1, p2, waiting;
  logic       m_any;
  int         entry [8];
  int         e;

  int         pc [8];
  int         rc [8];
  int         pat [8];
  int         rat [8];
  int         anyc;
  logic       saw_all;

  task automatic model_reset();
    m_db = 8'hFF; m_press = '0; m_rel = '0; m_any = 1'b0;
    p1 = 8'hFF; p2 = 8'hFF; waiting = '0; e = 0;
    for (int k = 0; k < 8; k++) entry[k] = 0;
  endtask

  task automatic model_edge();
    logic [7:0] s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e++;
    s = p2; p2 = p1; p1 = key_in;
    m_press = '0; m_rel = '0;
    for (int k = 0; k < 8; k++) begin
      if (s[k] == m_db[k]) begin
        waiting[k] = 1'b0;
      end else if (!waiting[k]) begin
        waiting[k] = 1'b1;
        entry[k]   = e;
      end else if ((e % TC == 0) && ((e / TC) - (entry[k] / TC) == DT)) begin
        m_db[k]    = s[k];
        waiting[k] = 1'b0;
        if (s[k]) m_rel[k] = 1'b1;
        else      m_press[k] = 1'b1;
      end
    end
    m_any = |m_press;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("key_db", 32'(key_db), 32'(m_db));
    chk("key_press", 32'(key_press), 32'(m_press));
    chk("key_release", 32'(key_release), 32'(m_rel));
    chk("key_any", 32'(key_any), 32'(m_any));
    chk("press_and_release", 32'(key_press & key_release), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (key_press[k] === 1'b1)   begin pc[k]++; pat[k] = cyc; end
      if (key_release[k] === 1'b1) begin rc[k]++; rat[k] = cyc; end
    end
    if (key_any === 1'b1) anyc++;
    if (key_press === 8'hFF) saw_all = 1'b1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 8; k++) begin pc[k] = 0; rc[k] = 0; pat[k] = 0; rat[k] = 0; end
    anyc = 0; saw_all = 1'b0;
  endtask

  task automatic tick1();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  int t0;
  int lat;

  initial begin
    key_in = 8'hFF;
    rst_n  = 1'b0;
    model_reset();
    clear_counts();
    run(3);
    rst_n = 1'b1;

    // Clean press on key 0.
    run(7);
    clear_counts();
    t0 = cyc;
    key_in[0] = 1'b0;
    run(60);
    lat = pat[0] - t0;
    chk("press0_count", 32'(pc[0]), 32'd1);
    chk("press0_window", 32'(lat >= 33 && lat <= 43), 32'd1);
    chk("press0_any_count", 32'(anyc), 32'd1);
    chk("press0_db", 32'(key_db), 32'h0000_00FE);

    // Bounce on key 3 is rejected.
    clear_counts();
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) key_in[3] = ~key_in[3];
      tick1();
    end
    key_in[3] = 1'b1;
    run(60);
    chk("bounce3_press", 32'(pc[3]), 32'd0);
    chk("bounce3_release", 32'(rc[3]), 32'd0);
    chk("bounce3_db", 32'(key_db[3]), 32'd1);

    // Release key 0.
    clear_counts();
    t0 = cyc;
    key_in[0] = 1'b1;
    run(60);
    lat = rat[0] - t0;
    chk("release0_count", 32'(rc[0]), 32'd1);
    chk("release0_window", 32'(lat >= 33 && lat <= 43), 32'd1);
    chk("release0_press", 32'(pc[0]), 32'd0);

    // All keys pressed together.
    clear_counts();
    key_in = 8'h00;
    run(60);
    chk("simul_all_press", 32'(saw_all), 32'd1);
    chk("simul_any_count", 32'(anyc), 32'd1);
    chk("simul_db", 32'(key_db), 32'd0);
    key_in = 8'hFF;
    run(60);

    // Reset in the middle of a wait on key 5, key kept low.
    clear_counts();
    key_in[5] = 1'b0;
    run(20);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run(3);
    chk("rst_db", 32'(key_db), 32'hFF);
    chk("rst_no_press", 32'(pc[5]), 32'd0);
    rst_n = 1'b1;
    clear_counts();
    t0 = cyc;
    run(60);
    lat = pat[5] - t0;
    chk("rst_press5_count", 32'(pc[5]), 32'd1);
    chk("rst_press5_window", 32'(lat >= 33 && lat <= 43), 32'd1);
    key_in = 8'hFF;
    run(60);

    // Long hold on key 7: single press, no repeats.
    clear_counts();
    key_in[7] = 1'b0;
    run(1000);
    chk("hold7_count", 32'(pc[7]), 32'd1);
    chk("hold7_db", 32'(key_db[7]), 32'd0);
    key_in[7] = 1'b1;
    run(60);

    // Random patterns with random hold lengths against the model.
    for (int n = 0; n < 40; n++) begin
      key_in = 8'($urandom);
      run(int'($urandom_range(1, 70)));
    end
    key_in = 8'hFF;
    run(60);
    chk("final_db", 32'(key_db), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions the eight raw push-button inputs before they reach the key PIO of the Nios II system; it sits directly upstream of the processor's key input.
- Per key: 2-FF synchronisation, tick-based debounce, then a clean stable level plus one-cycle press and release pulses.
- Runs in the 100 MHz system clock domain and is reset by the combined rst_n & PLL-locked reset.

Parameters:
- KEY_W, 8, number of keys.
- TICK_CYCLES, 100000, clock cycles per debounce tick (1 ms at 100 MHz).
- DEBOUNCE_TICKS, 20, consecutive ticks of steady input required to accept a level change.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  reset; asynchronous assert, active-low.
- key_in  input  KEY_W  raw keys, active-low (1 = released), asynchronous to clk.
- key_db  output  KEY_W  debounced level, same polarity as key_in; feeds key_export.
- key_press  output  KEY_W  one-cycle pulse when the debounced level goes 1->0.
- key_release  output  KEY_W  one-cycle pulse when the debounced level goes 0->1.
- key_any  output  1  registered OR of key_press, aligned with it.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all synchroniser flops = 1; key_db = all 1; key_press, key_release, key_any = 0; tick counter = 0; every channel in REL; every channel counter = 0.
- Synchroniser: 2 flops per key. The channel FSM sees key_sync = key_in delayed by 2 clk.
- Tick generator (shared by all channels):
  - Counter runs 0..TICK_CYCLES-1 and wraps.
  - tick = 1 for exactly the one cycle where the counter equals TICK_CYCLES-1.
  - Free-running; not restarted by key activity.
- Channel FSM, 4 states, 2-bit encoding:
  - REL (key_db=1): if key_sync==0 -> PWAIT, cnt=0.
  - PWAIT: if key_sync==1 -> REL (glitch rejected, no pulse). Else on tick cnt++. On the tick where cnt==DEBOUNCE_TICKS-1 -> PRS, key_db<=0, key_press pulse for 1 cycle.
  - PRS (key_db=0): if key_sync==1 -> RWAIT, cnt=0.
  - RWAIT: mirror of PWAIT. Return to 0 -> PRS, no pulse. On tick with cnt==DEBOUNCE_TICKS-1 -> REL, key_db<=1, key_release pulse.
- Glitch rule: any opposite-level sample in a WAIT state aborts the wait the same cycle. A later transition restarts the count from 0.
- Latency from a clean key_in edge to key_db change and pulse: at least 3+(DEBOUNCE_TICKS-1)*TICK_CYCLES cycles, at most 3+DEBOUNCE_TICKS*TICK_CYCLES cycles. The pulse is registered and coincides with the key_db transition.
- Counter width: clog2(DEBOUNCE_TICKS). It never exceeds DEBOUNCE_TICKS-1 (no wrap).
- Channels are fully independent. Simultaneous events on several keys give simultaneous pulses; key_any is the OR of those pulses.
- key_press and key_release of one key are never both 1 in the same cycle.
- Reset mid-debounce: the channel returns to REL with no pulse.
- Key held low across reset release: after 2 cycles the channel enters PWAIT and produces a normal key_press after debounce.
- Key held indefinitely: key_db stays 0 and there are no repeat pulses.

Decomposition:
- Package key_debounce_pkg:
  - state typedef: REL=2'b00, PWAIT=2'b01, PRS=2'b10, RWAIT=2'b11.
  - default parameter constants.
  - counter-width function (clog2).
- Sub-module key_debounce_ch: one per key, instantiated KEY_W times by generate.
  - Contains the synchroniser, the FSM and the counter.
  - Takes tick as an input.
- The top level holds only the tick generator, the generate loop and the key_any register.

Test Plan (sim with TICK_CYCLES=10, DEBOUNCE_TICKS=4):
- Clean press: key_in[0] 1->0 at cycle T and held -> key_db[0] falls and key_press[0] pulses once, 1 cycle wide, in window T+33..T+43; key_any pulses in the same cycle; other bits unchanged.
- Bounce rejection: key_in[3] toggles 0/1 every 7 cycles for 100 cycles, then returns to 1 -> key_db[3] stays 1; no key_press or key_release pulses at any time.
- Release: from the pressed state, key_in[0] 0->1 at T -> key_release[0] pulses once and key_db[0]=1 in window T+33..T+43; key_press stays 0.
- Simultaneous: key_in=8'h00 at T -> key_db=8'h00 and key_press=8'hFF in the same cycle; key_any=1 for 1 cycle.
- Reset mid-wait: press key 5, assert rst_n low 20 cycles later for 3 cycles -> key_db=8'hFF with no pulses during reset. Key still low after release -> exactly one key_press[5] in window 33..43 after rst_n rises.
- Long hold: key 7 held low for 1000 cycles -> exactly one key_press[7]; key_db[7]=0 throughout after acceptance.
